// File: rtl/smg_scan_ctrl.sv
// smg_scan_ctrl: time-multiplexed driver for a six-digit common-anode seven-segment display.
//
// Each digit owns a slot of SCAN_CNT clocks. The first BLANK_CNT clocks of every slot
// drive all digits off to stop ghosting while the segment lines settle. The 24-bit input
// is captured once per frame, at the first cycle of digit 0, so a frame never tears.
//
// Ports:
//   CLOCK    in   system clock, rising edge
//   RST      in   synchronous active-high reset
//   iData    in   six hex nibbles, nibble k drives digit k (digit 0 rightmost)
//   SMG_Data out  active-low segments {dp, g, f, e, d, c, b, a}, registered
//   Scan_Sig out  active-low digit enables, bit k selects digit k, registered
module smg_scan_ctrl #(
    parameter int unsigned SCAN_CNT  = 50000,
    parameter int unsigned BLANK_CNT = 500,
    parameter int unsigned LZ_SUPP   = 0
) (
    input  logic        CLOCK,
    input  logic        RST,
    input  logic [23:0] iData,
    output logic [7:0]  SMG_Data,
    output logic [5:0]  Scan_Sig
);

    localparam int unsigned       CNT_W     = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_CNT - 1);
    localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CNT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [23:0]      shadow_q, shadow_d;
    logic [7:0]       smg_d;
    logic [5:0]       scan_d;
    logic [3:0]       nib;
    logic [23:0]      upper;

    function automatic logic [7:0] seg_enc(input logic [3:0] n);
        logic [7:0] s;
        unique case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            4'hF: s = 8'h8E;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        // Capture only at frame start so all six digits show one coherent value.
        shadow_d = (cnt_q == '0 && idx_q == 3'd0) ? iData : shadow_q;

        nib = 4'h0;
        case (idx_q)
            3'd0:    nib = shadow_q[3:0];
            3'd1:    nib = shadow_q[7:4];
            3'd2:    nib = shadow_q[11:8];
            3'd3:    nib = shadow_q[15:12];
            3'd4:    nib = shadow_q[19:16];
            3'd5:    nib = shadow_q[23:20];
            default: nib = 4'h0;
        endcase

        // Nibbles idx..5; all zero means this digit is a leading zero.
        upper = shadow_q >> {idx_q, 2'b00};

        if (cnt_q < BLANK_END) begin
            scan_d = 6'h3F;
            smg_d  = 8'hFF;
        end else begin
            scan_d = ~(6'd1 << idx_q);
            if (LZ_SUPP == 1 && idx_q != 3'd0 && upper == 24'h0) begin
                smg_d = 8'hFF;
            end else begin
                smg_d = seg_enc(nib);
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            shadow_q <= 24'h0;
            SMG_Data <= 8'hFF;
            Scan_Sig <= 6'h3F;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            SMG_Data <= smg_d;
            Scan_Sig <= scan_d;
        end
    end

endmodule
